ni_request_payload_serializer: RTL and testbench



---
 rtl/ni_request_payload_serializer_pkg.sv | 29 ++
 rtl/ni_request_payload_serializer_chunk_mux.sv | 35 +++
 rtl/ni_request_payload_serializer.sv | 186 ++++++++++++++++++
 tb/tb_ni_request_payload_serializer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ni_request_payload_serializer_pkg.sv
// ---------------------------------------------------------------------------
// ni_request_payload_serializer_pkg
// Shared definitions for the NI request payload serializer:
//   - FTYPE_WIDTH_DEF : default flit-type field width prepended by the builder
//   - clog2()         : ceiling log2, used to size count/index fields
//   - state_e         : serializer FSM encoding (ST_IDLE / ST_SEND)
// ---------------------------------------------------------------------------
package ni_request_payload_serializer_pkg;

   localparam int FTYPE_WIDTH_DEF = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/ni_request_payload_serializer_chunk_mux.sv
// ---------------------------------------------------------------------------
// ni_payload_chunk_mux
// Purely combinational chunk selector: returns chunk idx_i of payload_i
// (chunk k = payload_i[BASE_WIDTH*k +: BASE_WIDTH]), or zero when en_i is low.
// Ports:
//   payload_i  PAYLOAD  full captured payload
//   idx_i      CNT      chunk index
//   en_i       1        output gate; data_o is zero when low
//   data_o     BASE     selected chunk
// ---------------------------------------------------------------------------
module ni_payload_chunk_mux #(
   parameter int BASE_WIDTH = 30,
   parameter int MAX_FLITS  = 4,
   parameter int CNT_WIDTH  = 3
) (
   input  logic [BASE_WIDTH*MAX_FLITS-1:0] payload_i,
   input  logic [CNT_WIDTH-1:0]            idx_i,
   input  logic                            en_i,
   output logic [BASE_WIDTH-1:0]           data_o
);

   // Compare-and-select per chunk so an index beyond MAX_FLITS-1 yields zero
   // instead of an out-of-range part-select.
   always_comb begin
      data_o = {BASE_WIDTH{1'b0}};
      for (int k = 0; k < MAX_FLITS; k++) begin
         if (en_i && (idx_i == CNT_WIDTH'(k))) begin
            data_o = payload_i[BASE_WIDTH*k +: BASE_WIDTH];
         end else begin
            data_o = data_o;
         end
      end
   end

endmodule

// File: rtl/ni_request_payload_serializer.sv
// ---------------------------------------------------------------------------
// ni_request_payload_serializer
// Captures a whole request payload in one load handshake and streams it to
// the NI flit builder as BASE_WIDTH-wide chunks, lowest chunk first.
// Optional feature macro: NI_PAYLOAD_PARITY_EN (adds chunk_parity output).
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   load_valid/ready    payload handshake (load_ready is combinational)
//   load_payload        chunk k at [BASE_WIDTH*k +: BASE_WIDTH]
//   load_nflits         chunks to send (clamped to MAX_FLITS, 0 = drop)
//   chunk_valid/ready   chunk handshake towards the flit builder
//   chunk_data/idx/last current chunk, its index, tail marker (registered)
//   abort               synchronous flush, highest priority
//   busy                high while in SEND
//   chunk_parity        XOR of chunk_data (only with NI_PAYLOAD_PARITY_EN)
// ---------------------------------------------------------------------------
module ni_request_payload_serializer
   import ni_request_payload_serializer_pkg::*;
#(
   parameter  int FLIT_WIDTH    = 32,
   parameter  int FTYPE_WIDTH   = FTYPE_WIDTH_DEF,
   parameter  int MAX_FLITS     = 4,
   localparam int BASE_WIDTH    = FLIT_WIDTH - FTYPE_WIDTH,
   localparam int PAYLOAD_WIDTH = BASE_WIDTH * MAX_FLITS,
   localparam int CNT_WIDTH     = clog2(MAX_FLITS + 1)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [PAYLOAD_WIDTH-1:0] load_payload,
   input  logic [CNT_WIDTH-1:0]     load_nflits,
   output logic                     chunk_valid,
   input  logic                     chunk_ready,
   output logic [BASE_WIDTH-1:0]    chunk_data,
   output logic [CNT_WIDTH-1:0]     chunk_idx,
   output logic                     chunk_last,
   input  logic                     abort,
   output logic                     busy
`ifdef NI_PAYLOAD_PARITY_EN
   ,
   output logic                     chunk_parity
`endif
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_FLITS);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_e                   state_q, state_d;
   logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
   logic [CNT_WIDTH-1:0]     nflits_q, nflits_d;
   logic [CNT_WIDTH-1:0]     idx_q, idx_d;

   logic                     chunk_valid_q, chunk_valid_d;
   logic [BASE_WIDTH-1:0]    chunk_data_q, chunk_data_d;
   logic [CNT_WIDTH-1:0]     chunk_idx_q, chunk_idx_d;
   logic                     chunk_last_q, chunk_last_d;

   logic                     accept;
   logic [CNT_WIDTH-1:0]     nflits_clamped;
   logic                     send_d;

   // Acceptance: idle, or the tail chunk is leaving this cycle; never on abort.
   always_comb begin
      if (abort) begin
         load_ready = 1'b0;
      end else if (state_q == ST_IDLE) begin
         load_ready = 1'b1;
      end else begin
         load_ready = chunk_valid_q & chunk_ready & chunk_last_q;
      end
      accept = load_valid & load_ready;
      if (load_nflits > MAX_CNT) begin
         nflits_clamped = MAX_CNT;
      end else begin
         nflits_clamped = load_nflits;
      end
   end

   // Next-state: abort beats load, load beats chunk advance.
   always_comb begin
      state_d   = state_q;
      payload_d = payload_q;
      nflits_d  = nflits_q;
      idx_d     = idx_q;
      if (abort) begin
         state_d = ST_IDLE;
         idx_d   = CNT_ZERO;
      end else if (accept) begin
         payload_d = load_payload;
         nflits_d  = nflits_clamped;
         idx_d     = CNT_ZERO;
         if (nflits_clamped != CNT_ZERO) begin
            state_d = ST_SEND;
         end else begin
            state_d = ST_IDLE;
         end
      end else if ((state_q == ST_SEND) && chunk_valid_q && chunk_ready) begin
         if (chunk_last_q) begin
            state_d = ST_IDLE;
            idx_d   = CNT_ZERO;
         end else begin
            idx_d = idx_q + CNT_ONE;
         end
      end else begin
         state_d = state_q;
      end
   end

   assign send_d = (state_d == ST_SEND);

   // Outputs are precomputed from next state so they can be registered
   // while still appearing the cycle after accept.
   ni_payload_chunk_mux #(
      .BASE_WIDTH (BASE_WIDTH),
      .MAX_FLITS  (MAX_FLITS),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_chunk_mux (
      .payload_i (payload_d),
      .idx_i     (idx_d),
      .en_i      (send_d),
      .data_o    (chunk_data_d)
   );

   // Next output values, all zero outside SEND.
   always_comb begin
      chunk_valid_d = send_d;
      if (send_d) begin
         chunk_idx_d  = idx_d;
         chunk_last_d = (idx_d == (nflits_d - CNT_ONE));
      end else begin
         chunk_idx_d  = CNT_ZERO;
         chunk_last_d = 1'b0;
      end
   end

   // State, payload, counters and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         payload_q     <= {PAYLOAD_WIDTH{1'b0}};
         nflits_q      <= CNT_ZERO;
         idx_q         <= CNT_ZERO;
         chunk_valid_q <= 1'b0;
         chunk_data_q  <= {BASE_WIDTH{1'b0}};
         chunk_idx_q   <= CNT_ZERO;
         chunk_last_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         payload_q     <= payload_d;
         nflits_q      <= nflits_d;
         idx_q         <= idx_d;
         chunk_valid_q <= chunk_valid_d;
         chunk_data_q  <= chunk_data_d;
         chunk_idx_q   <= chunk_idx_d;
         chunk_last_q  <= chunk_last_d;
      end
   end

   assign chunk_valid = chunk_valid_q;
   assign chunk_data  = chunk_data_q;
   assign chunk_idx   = chunk_idx_q;
   assign chunk_last  = chunk_last_q;
   assign busy        = (state_q == ST_SEND);

`ifdef NI_PAYLOAD_PARITY_EN
   logic parity_q;

   function automatic logic even_parity(input logic [BASE_WIDTH-1:0] d);
      return ^d;
   endfunction

   // Parity register tracks chunk_data_q (zero data gives zero parity).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= even_parity(chunk_data_d);
      end
   end

   assign chunk_parity = parity_q;
`endif

endmodule

// File: tb/tb_ni_request_payload_serializer.sv
module tb_ni_request_payload_serializer;

   localparam int BW = 30;
   localparam int MF = 4;
   localparam int PW = BW * MF;
   localparam int CW = 3;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [PW-1:0] load_payload = '0;
   logic [CW-1:0] load_nflits = '0;
   logic          chunk_valid;
   logic          chunk_ready = 1'b1;
   logic [BW-1:0] chunk_data;
   logic [CW-1:0] chunk_idx;
   logic          chunk_last;
   logic          abort = 1'b0;
   logic          busy;
`ifdef NI_PAYLOAD_PARITY_EN
   logic          chunk_parity;
`endif

   ni_request_payload_serializer dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_payload (load_payload),
      .load_nflits  (load_nflits),
      .chunk_valid  (chunk_valid),
      .chunk_ready  (chunk_ready),
      .chunk_data   (chunk_data),
      .chunk_idx    (chunk_idx),
      .chunk_last   (chunk_last),
      .abort        (abort),
      .busy         (busy)
`ifdef NI_PAYLOAD_PARITY_EN
      ,
      .chunk_parity (chunk_parity)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [BW-1:0] d;
      logic [CW-1:0] i;
      logic          l;
   } exp_t;

   exp_t expq[$];
   int   total = 0;
   int   bad = 0;
   int   acc_cnt = 0;
   bit   mon_en = 1'b0;
   bit   rnd_mode = 1'b0;
   bit   rdy_val = 1'b1;
   bit   abort_dir = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // chunk_ready / abort driver, settles 1 time unit after each negedge
   always @(negedge clock) begin
      #1;
      if (rnd_mode) begin
         chunk_ready = ($urandom % 4) != 0;
         abort       = ($urandom % 30) == 0;
      end else begin
         chunk_ready = rdy_val;
         abort       = abort_dir;
      end
   end

   // Monitor / scoreboard, samples just before the rising edge
   int            m_n;
   bit            m_exp_ready;
   bit            held = 1'b0;
   logic [BW-1:0] prev_d;
   logic [CW-1:0] prev_i;
   logic          prev_l;
   exp_t          e;
   int            m_cnt;

   always @(negedge clock) begin
      #4;
      if (mon_en) begin
         m_n = expq.size();
         chk("chunk_valid", chunk_valid, m_n > 0);
         chk("busy", busy, m_n > 0);
         // only one packet is ever in flight: one entry left means the tail
         m_exp_ready = !abort && (m_n == 0 || (chunk_ready && m_n == 1));
         chk("load_ready", load_ready, m_exp_ready);
         if (!chunk_valid) begin
            chk("idle_data_zero", chunk_data, 0);
            chk("idle_idx_zero", chunk_idx, 0);
`ifdef NI_PAYLOAD_PARITY_EN
            chk("idle_parity_zero", chunk_parity, 0);
`endif
         end
         if (held && chunk_valid) begin
            chk("hold_data", chunk_data, prev_d);
            chk("hold_idx", chunk_idx, prev_i);
            chk("hold_last", chunk_last, prev_l);
         end
         if (abort) begin
            expq.delete();
         end else if (chunk_valid && chunk_ready && m_n > 0) begin
            e = expq.pop_front();
            chk("chunk_data", chunk_data, e.d);
            chk("chunk_idx", chunk_idx, e.i);
            chk("chunk_last", chunk_last, e.l);
`ifdef NI_PAYLOAD_PARITY_EN
            chk("chunk_parity", chunk_parity, ^e.d);
`endif
         end
         if (load_valid && load_ready) begin
            acc_cnt++;
            m_cnt = (int'(load_nflits) > MF) ? MF : int'(load_nflits);
            for (int k = 0; k < m_cnt; k++) begin
               e.d = load_payload[BW*k +: BW];
               e.i = CW'(k);
               e.l = (k == m_cnt - 1);
               expq.push_back(e);
            end
         end
         held   = chunk_valid && !chunk_ready && !abort;
         prev_d = chunk_data;
         prev_i = chunk_idx;
         prev_l = chunk_last;
      end
   end

   // Present a payload at the next negedge; returns on the edge that takes it.
   task automatic offer(input logic [PW-1:0] p, input int n);
      int c0;
      bit got;
      @(negedge clock);
      load_payload = p;
      load_nflits  = CW'(n);
      load_valid   = 1'b1;
      c0  = acc_cnt;
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
         @(posedge clock);
         got = (acc_cnt != c0);
      end
      if (!got) begin
         bad++;
         total++;
         $display("FAIL accept_timeout: got none expected accept of n=%0d", n);
      end
   endtask

   task automatic idle_load();
      @(negedge clock);
      load_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (expq.size() != 0 && t < 200) begin
         @(posedge clock);
         t++;
      end
      repeat (2) @(posedge clock);
      chk("drain_empty", expq.size(), 0);
   endtask

   function automatic logic [PW-1:0] rnd_payload();
      logic [PW-1:0] p;
      p = {$urandom, $urandom, $urandom, $urandom};
      return p;
   endfunction

   initial begin
      logic [PW-1:0] p;
      // reset state
      #1;
      chk("rst_load_ready", load_ready, 1);
      chk("rst_chunk_valid", chunk_valid, 0);
      chk("rst_chunk_data", chunk_data, 0);
      chk("rst_chunk_idx", chunk_idx, 0);
      chk("rst_chunk_last", chunk_last, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // basic: chunks A=7, B, C, D unused
      rdy_val = 1'b1;
      p = {30'h2AAA_5555, 30'h0333_CCCC, 30'h1234_5678, 30'h0000_0007};
      offer(p, 3);
      idle_load();
      drain();

      // backpressure on chunk 0 for 3 cycles
      @(negedge clock);
      rdy_val = 1'b0;
      offer({30'h0, 30'h0, 30'h3FFF_FFFF, 30'h0ABC_DEF1}, 2);
      idle_load();
      repeat (2) @(negedge clock);
      rdy_val = 1'b1;
      drain();

      // back-to-back P1 (2 flits) then P2 (1 flit)
      offer({30'h0, 30'h0, 30'h1111_1111, 30'h2222_2222}, 2);
      offer({30'h0, 30'h0, 30'h0, 30'h3333_3333}, 1);
      idle_load();
      drain();

      // zero count and clamped count
      offer(rnd_payload(), 0);
      idle_load();
      drain();
      offer(rnd_payload(), 7);
      idle_load();
      drain();

      // abort during idx 1 of a 4-flit packet, load offered in abort cycle
      offer(rnd_payload(), 4);
      idle_load();                     // chunk 0 handshakes this cycle
      @(negedge clock);                // idx 1 now presented
      abort_dir    = 1'b1;
      load_payload = rnd_payload();
      load_nflits  = CW'(2);
      load_valid   = 1'b1;
      @(negedge clock);
      abort_dir = 1'b0;
      for (int t = 0; t < 5 && load_valid; t++) begin
         @(posedge clock);
         if (expq.size() != 0) begin
            @(negedge clock);
            load_valid = 1'b0;
         end
      end
      drain();

      // asynchronous reset in the middle of a packet
      rdy_val = 1'b0;
      offer(rnd_payload(), 4);
      idle_load();
      @(negedge clock);
      #2;
      mon_en  = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("arst_chunk_valid", chunk_valid, 0);
      chk("arst_chunk_data", chunk_data, 0);
      chk("arst_chunk_idx", chunk_idx, 0);
      chk("arst_chunk_last", chunk_last, 0);
      chk("arst_busy", busy, 0);
      chk("arst_load_ready", load_ready, 1);
`ifdef NI_PAYLOAD_PARITY_EN
      chk("arst_parity", chunk_parity, 0);
`endif
      expq.delete();
      held    = 1'b0;
      rdy_val = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // randomized traffic with random backpressure and aborts
      rnd_mode = 1'b1;
      for (int k = 0; k < 60; k++) begin
         offer(rnd_payload(), $urandom_range(0, 7));
         if (($urandom % 3) == 0) begin
            idle_load();
            repeat ($urandom_range(0, 3)) @(negedge clock);
         end
      end
      idle_load();
      rnd_mode  = 1'b0;
      rdy_val   = 1'b1;
      abort_dir = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
